// File: rtl/rom_fetch_pkg.sv
// Shared types and default widths for the code-ROM fetch unit.
package rom_fetch_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/rom_fetch_unit_buf.sv
// Small synchronous FIFO holding fetched {addr, data} entries for the decoder.
module fetch_buf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 22
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[PW'(i)] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rom_fetch_unit.sv
// Read master for the code ROM: issues sequential reads, captures Q a cycle later
// and streams {word, address} to the decoder over valid/ready, with start/stop/jump.
module rom_fetch_unit
  import rom_fetch_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int START_ADDR = 0,
  parameter int BUF_DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              CEN,
  output logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] Q,
  input  logic              start,
  input  logic              stop,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ready,
  output logic              busy
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, a_last;
  logic              inflight, issue, push, pop, room;
  logic              empty, full;
  logic [CNT_W-1:0]  count;
  logic [OCC_W-1:0]  occ;
  logic [ENT_W-1:0]  head;

  assign pop  = !empty && instr_ready;
  // The read in flight lands this cycle; a jump in the same cycle discards it.
  assign push = inflight && !jump_valid;
  // Slot freed by this cycle's pop counts as available, sustaining 1 word/cycle.
  assign occ  = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign room = !(full && !pop) && (occ < OCC_W'(BUF_DEPTH));

  fetch_buf #(
    .DEPTH(BUF_DEPTH),
    .W    (ENT_W)
  ) u_buf (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (jump_valid),
    .push     (push),
    .push_data({a_last, Q}),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    issue    = 1'b0;
    unique case (state)
      IDLE: begin
        if (jump_valid) begin
          state_nx = RUN;
          pc_nx    = jump_addr;
        end else if (start && !stop) begin
          state_nx = RUN;
          pc_nx    = ADDR_W'(START_ADDR);
        end
      end
      RUN: begin
        if (jump_valid) begin
          pc_nx = jump_addr;
        end else begin
          if (stop) state_nx = DRAIN;
          if (room) begin
            issue = 1'b1;
            pc_nx = pc + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (jump_valid) begin
          state_nx = RUN;
          pc_nx    = jump_addr;
        end else if (empty && !inflight) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      pc       <= ADDR_W'(START_ADDR);
      inflight <= 1'b0;
      a_last   <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      inflight <= issue;
      if (issue) a_last <= pc;
    end
  end

  assign CEN         = !issue;
  assign A           = issue ? pc : a_last;
  assign busy        = (state != IDLE);
  assign instr_valid = !empty;
  assign instr_addr  = head[ENT_W-1:DATA_W];
  assign instr_data  = head[DATA_W-1:0];

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: behavioural ROM, transaction scoreboard, directed and random stimulus.
module tb_rom_fetch_unit;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 16;
  localparam int BUF_DEPTH  = 2;
  localparam int START_ADDR = 0;
  localparam int M_IDLE     = 0;
  localparam int M_RUN      = 1;
  localparam int M_DRAIN    = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              CEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] Q = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              jump_valid = 1'b0;
  logic [ADDR_W-1:0] jump_addr = '0;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_ready = 1'b0;
  logic              busy;

  int checks = 0;
  int failures = 0;
  int delivered = 0;

  // Reference model: fetch mode, next expected read address, reads issued but not yet consumed.
  int                mode = M_IDLE;
  logic [ADDR_W-1:0] iss_next = ADDR_W'(START_ADDR);
  logic [ADDR_W-1:0] pend[$];
  logic [ADDR_W-1:0] got[$];
  bit                hold_prev = 1'b0;

  rom_fetch_unit #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .START_ADDR(START_ADDR),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CEN        (CEN),
    .A          (A),
    .Q          (Q),
    .start      (start),
    .stop       (stop),
    .jump_valid (jump_valid),
    .jump_addr  (jump_addr),
    .instr_valid(instr_valid),
    .instr_data (instr_data),
    .instr_addr (instr_addr),
    .instr_ready(instr_ready),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // ROM contents: word i = 16'hA000 + i
  always @(posedge CLK) if (CEN === 1'b0) Q <= 16'hA000 + 16'(A);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic half();
    @(negedge CLK);
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_step();
    int sz0;
    logic [ADDR_W-1:0] f;
    if (RST) begin
      pend.delete();
      mode = M_IDLE;
      iss_next = ADDR_W'(START_ADDR);
      hold_prev = 1'b0;
      return;
    end
    sz0 = pend.size();
    chk("busy", busy, mode != M_IDLE);
    if (mode != M_RUN || jump_valid) chk("cen_quiet", CEN, 1);
    if (mode == M_IDLE) chk("valid_idle", instr_valid, 0);
    if (hold_prev) chk("valid_held", instr_valid, 1);
    if (instr_valid === 1'b1) begin
      if (sz0 == 0) chk("spurious_valid", instr_valid, 0);
      else begin
        f = pend[0];
        chk("instr_addr", instr_addr, f);
        chk("instr_data", instr_data, 16'hA000 + 16'(f));
      end
    end
    if (instr_valid === 1'b1 && instr_ready && sz0 > 0) begin
      got.push_back(pend.pop_front());
      delivered++;
    end
    if (CEN === 1'b0) begin
      chk("issue_addr", A, iss_next);
      pend.push_back(iss_next);
      iss_next = iss_next + ADDR_W'(1);
    end
    chk("occupancy", pend.size() <= BUF_DEPTH, 1);
    hold_prev = (instr_valid === 1'b1) && !instr_ready && !jump_valid;
    if (jump_valid) begin
      pend.delete();
      mode = M_RUN;
      iss_next = jump_addr;
    end else begin
      case (mode)
        M_IDLE:  if (start && !stop) begin mode = M_RUN; iss_next = ADDR_W'(START_ADDR); end
        M_RUN:   if (stop) mode = M_DRAIN;
        default: if (sz0 == 0) mode = M_IDLE;
      endcase
    end
  endtask

  task automatic cyc();
    half();
    model_step();
    adv();
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      half();
      if (instr_valid === 1'b1) begin ok = 1'b1; return; end
      model_step();
      adv();
    end
    half();
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      half();
      if (busy === 1'b0) begin ok = 1'b1; return; end
      model_step();
      adv();
    end
    half();
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_cen"}, CEN, 1);
    chk({pfx, "_a"}, A, 0);
    chk({pfx, "_valid"}, instr_valid, 0);
    chk({pfx, "_data"}, instr_data, 0);
    chk({pfx, "_addr"}, instr_addr, 0);
    chk({pfx, "_busy"}, busy, 0);
  endtask

  initial begin
    bit ok;
    logic [ADDR_W-1:0] wexp [4];
    wexp[0] = 6'h3E; wexp[1] = 6'h3F; wexp[2] = 6'h00; wexp[3] = 6'h01;

    RST = 1'b1;
    repeat (2) cyc();
    RST = 1'b0;
    half(); reset_checks("rst"); model_step(); adv();

    // start with ready high: first read cycle 1, first word cycle 3, back-to-back
    instr_ready = 1'b1; start = 1'b1;
    half(); chk("c0_cen", CEN, 1); model_step(); adv();
    start = 1'b0;
    half(); chk("c1_cen", CEN, 0); chk("c1_a", A, 0); model_step(); adv();
    half(); chk("c2_a", A, 1); chk("c2_valid", instr_valid, 0); model_step(); adv();
    half(); chk("c3_valid", instr_valid, 1); chk("c3_data", instr_data, 16'hA000);
    chk("c3_addr", instr_addr, 0); chk("c3_cen", CEN, 0); model_step(); adv();
    half(); chk("c4_valid", instr_valid, 1); chk("c4_data", instr_data, 16'hA001);
    model_step(); adv();
    repeat (4) cyc();

    // back-pressure: reads stop, head held, then stream resumes
    instr_ready = 1'b0;
    repeat (8) cyc();
    half(); chk("stall_cen", CEN, 1); chk("stall_valid", instr_valid, 1); model_step(); adv();
    instr_ready = 1'b1;
    repeat (6) cyc();

    // redirect while the buffer is full
    instr_ready = 1'b0;
    repeat (4) cyc();
    jump_valid = 1'b1; jump_addr = 6'h20;
    cyc();
    jump_valid = 1'b0;
    wait_valid(10, ok);
    chk("jump_seen", ok, 1); chk("jump_addr", instr_addr, 6'h20); chk("jump_data", instr_data, 16'hA020);
    model_step(); adv();

    // address wrap at the top of the ROM
    instr_ready = 1'b1; jump_valid = 1'b1; jump_addr = 6'h3E;
    cyc();
    jump_valid = 1'b0;
    got.delete();
    repeat (8) cyc();
    chk("wrap_count", got.size() >= 4, 1);
    for (int i = 0; i < 4; i++) if (i < got.size()) chk("wrap_seq", got[i], wexp[i]);

    // stop: no new read next cycle, drain, then idle
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    half(); chk("stop_cen", CEN, 1); model_step(); adv();
    wait_idle(20, ok);
    chk("stop_idle", ok, 1); chk("stop_valid", instr_valid, 0);
    model_step(); adv();

    // stop and jump together: jump wins
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    stop = 1'b1; jump_valid = 1'b1; jump_addr = 6'h10;
    cyc();
    stop = 1'b0; jump_valid = 1'b0;
    half(); chk("sj_busy", busy, 1); chk("sj_cen", CEN, 0); chk("sj_a", A, 6'h10);
    model_step(); adv();
    repeat (5) cyc();

    // reset mid-stream, then restart from the start address
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    half(); reset_checks("mrst"); model_step(); adv();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_valid(10, ok);
    chk("restart_seen", ok, 1); chk("restart_data", instr_data, 16'hA000); chk("restart_addr", instr_addr, 0);
    model_step(); adv();

    delivered = 0;
    for (int n = 0; n < 3000; n++) begin
      instr_ready = ($urandom_range(0, 99) < 70);
      start       = ($urandom_range(0, 99) < 8);
      stop        = ($urandom_range(0, 99) < 3);
      jump_valid  = ($urandom_range(0, 99) < 3);
      jump_addr   = ADDR_W'($urandom);
      RST         = ($urandom_range(0, 999) < 3);
      cyc();
    end
    RST = 1'b0; start = 1'b0; stop = 1'b0; jump_valid = 1'b0;
    chk("random_progress", delivered > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
